// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision constants and types for the FP datapath.
package fpu_pkg;

    localparam int unsigned EXP_BITS  = 8;
    localparam int unsigned FRAC_BITS = 23;
    localparam int unsigned SIG_BITS  = 24;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXP_INF   = 2 * BIAS + 1;
    // Wide enough that exp+1 on 255 and exp-k never wrap.
    localparam int unsigned EXP_INT_W = 10;

    localparam int unsigned FLAG_OVF = 2;
    localparam int unsigned FLAG_UNF = 1;
    localparam int unsigned FLAG_INX = 0;

    localparam logic [EXP_BITS-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic                 sign;
        logic [EXP_INT_W-1:0] exp;
        logic [SIG_BITS-1:0]  mant;
        logic                 g;
        logic                 r;
        logic                 s;
    } norm_t;

    function automatic logic [EXP_BITS+FRAC_BITS:0] pack_single(
        input logic                 sign,
        input logic [EXP_BITS-1:0]  exp,
        input logic [FRAC_BITS-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero count of a 24-bit significand; an all-zero input counts as 24.
module fp_lzc24 (
    input  logic [23:0] data,
    output logic [4:0]  count
);

    // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (data[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalize (S1) and round-to-nearest-even/pack (S2) for single-precision sums.
module fp_normalize_round
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W:0]         in_mant,
    input  logic [2:0]             in_grs,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_result,
    output logic [2:0]             out_flags
);

    logic  s1_valid_q;
    logic  s2_valid_q;
    norm_t s1_d;
    norm_t s1_q;
    logic  s2_ready;

    assign s2_ready  = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_ready;
    assign out_valid = s2_valid_q;

    // S1: normalize
    logic [4:0]           lz;
    logic [EXP_INT_W-1:0] exp_in;
    logic [EXP_INT_W-1:0] lz_ext;
    logic [EXP_INT_W-1:0] k;
    logic [25:0]          shifted;

    fp_lzc24 u_lzc (
        .data  (in_mant[23:0]),
        .count (lz)
    );

    assign exp_in = EXP_INT_W'(in_exp);
    assign lz_ext = EXP_INT_W'(lz);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        k         = '0;
        shifted   = '0;
        if (in_mant[24]) begin
            s1_d.mant = in_mant[24:1];
            s1_d.exp  = exp_in + EXP_INT_W'(1);
            s1_d.g    = in_mant[0];
            s1_d.r    = in_grs[2];
            s1_d.s    = in_grs[1] | in_grs[0];
        end else begin
            if (exp_in != '0) begin
                k = (lz_ext < exp_in - EXP_INT_W'(1)) ? lz_ext : exp_in - EXP_INT_W'(1);
            end
            // Guard then round are shifted in behind the significand; sticky stays put.
            shifted   = {in_mant[23:0], in_grs[2:1]} << k;
            s1_d.mant = shifted[25:2];
            s1_d.g    = shifted[1];
            s1_d.r    = shifted[0];
            s1_d.s    = in_grs[0];
            s1_d.exp  = shifted[25] ? exp_in - k : '0;
        end
    end

    // S2: round to nearest even and pack
    logic                   inc;
    logic [SIG_BITS:0]      sum;
    logic [EXP_INT_W-1:0]   exp_r;
    logic [FRAC_BITS-1:0]   frac;
    logic                   inexact;
    logic [EXP_W+MAN_W-1:0] result_d;
    logic [2:0]             flags_d;

    always_comb begin
        inc     = s1_q.g & (s1_q.r | s1_q.s | s1_q.mant[0]);
        sum     = {1'b0, s1_q.mant} + {{SIG_BITS{1'b0}}, inc};
        inexact = s1_q.g | s1_q.r | s1_q.s;
        exp_r   = s1_q.exp + {{(EXP_INT_W-1){1'b0}}, sum[24]};
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (s1_q.exp == '0 && sum[23]) begin
            exp_r = EXP_INT_W'(1);
        end
        frac    = sum[24] ? '0 : sum[22:0];
        flags_d = '0;
        if (exp_r >= EXP_INT_W'(EXP_INF)) begin
            result_d          = pack_single(s1_q.sign, EXP_MAX, '0);
            flags_d[FLAG_OVF] = 1'b1;
            flags_d[FLAG_INX] = 1'b1;
        end else begin
            result_d          = pack_single(s1_q.sign, exp_r[EXP_BITS-1:0], frac);
            flags_d[FLAG_UNF] = inexact & (exp_r == '0);
            flags_d[FLAG_INX] = inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid_q <= 1'b1;
                s1_q       <= s1_d;
            end else if (s2_ready) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_valid_q && s2_ready) begin
                s2_valid_q <= 1'b1;
                out_result <= result_d;
                out_flags  <= flags_d;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench: directed vectors plus randomized traffic against a behavioural model.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int tests = 0;
    int fails = 0;
    logic [34:0] sb[$];

    always #5 clk = ~clk;

    fp_normalize_round #(
        .EXP_W (8),
        .MAN_W (24)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_grs     (in_grs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Returns {flags[2:0], result[31:0]} computed straight from the normalize/round rules.
    function automatic logic [34:0] model(input logic sign, input logic [7:0] e_in,
                                          input logic [24:0] mant, input logic [2:0] grs);
        int          e;
        int          lz;
        int          k;
        logic [23:0] m;
        logic        g;
        logic        r;
        logic        s;
        logic        inx;
        int unsigned sum;
        logic [2:0]  fl;
        logic [31:0] res;
        if (mant[24]) begin
            m = mant[24:1];
            e = int'(e_in) + 1;
            g = mant[0];
            r = grs[2];
            s = grs[1] | grs[0];
        end else begin
            m  = mant[23:0];
            g  = grs[2];
            r  = grs[1];
            s  = grs[0];
            e  = int'(e_in);
            lz = 0;
            while (lz < 24 && !m[23-lz]) lz++;
            k = (e == 0) ? 0 : ((lz < e - 1) ? lz : e - 1);
            for (int i = 0; i < k; i++) begin
                m = {m[22:0], g};
                g = r;
                r = 1'b0;
            end
            e = m[23] ? e - k : 0;
        end
        inx = g | r | s;
        sum = 32'(m) + 32'(g & (r | s | m[0]));
        if (sum >= 32'h0100_0000) begin
            e   = e + 1;
            sum = 0;
        end else if (e == 0 && sum >= 32'h0080_0000) begin
            e = 1;
        end
        if (e >= 255) begin
            res = {sign, 8'hFF, 23'h0};
            fl  = 3'b101;
        end else begin
            res = {sign, 8'(e), sum[22:0]};
            fl  = {1'b0, inx && (e == 0), inx};
        end
        return {fl, res};
    endfunction

    task automatic rand_operand();
        logic [24:0] m;
        int          sel;
        m   = 25'($urandom);
        sel = $urandom_range(0, 4);
        case (sel)
            0: m = m >> $urandom_range(0, 25);
            1: m[24] = 1'b1;
            2: m = {2'b01, m[22:0]};
            3: m = '0;
            default: ;
        endcase
        in_mant = m;
        sel = $urandom_range(0, 3);
        case (sel)
            0: in_exp = 8'($urandom_range(0, 3));
            1: in_exp = 8'($urandom_range(252, 255));
            default: in_exp = 8'($urandom);
        endcase
        in_grs  = 3'($urandom);
        in_sign = 1'($urandom);
    endtask

    task automatic send_directed(input string name, input logic sign, input logic [7:0] e,
                                 input logic [24:0] m, input logic [2:0] grs,
                                 input logic [34:0] req);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_sign   = sign;
        in_exp    = e;
        in_mant   = m;
        in_grs    = grs;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_ready"}, 35'(in_ready), 35'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_early"}, 35'(out_valid), 35'd0);
        @(negedge clk);
        check({name, "_valid"}, 35'(out_valid), 35'd1);
        check(name, {out_flags, out_result}, req);
    endtask

    // Scoreboard: record accepted operands, compare every transfer and every stalled cycle.
    initial begin
        logic        stalled;
        logic [34:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 35'(out_valid), 35'd1);
                    check("hold_data", {out_flags, out_result}, held);
                end
                if (in_valid && in_ready) begin
                    sb.push_back(model(in_sign, in_exp, in_mant, in_grs));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_output: got %h, required no output",
                                 {out_flags, out_result});
                    end else begin
                        check("result", {out_flags, out_result}, sb.pop_front());
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {out_flags, out_result};
            end
        end
    end

    initial begin
        logic took;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_grs    = '0;
        out_ready = 1'b0;

        check("model_one",   model(1'b0, 8'd127, 25'h0800000, 3'b000), {3'b000, 32'h3F80_0000});
        check("model_carry", model(1'b0, 8'd127, 25'h1000000, 3'b000), {3'b000, 32'h4000_0000});
        check("model_tie",   model(1'b0, 8'd127, 25'h0800001, 3'b100), {3'b001, 32'h3F80_0002});
        check("model_lz23",  model(1'b0, 8'd127, 25'h0000001, 3'b000), {3'b000, 32'h3400_0000});
        check("model_ovf",   model(1'b0, 8'd254, 25'h1FFFFFF, 3'b000), {3'b101, 32'h7F80_0000});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 35'(out_valid), 35'd0);
        check("reset_out_data", {out_flags, out_result}, 35'd0);
        check("reset_in_ready", 35'(in_ready), 35'd1);

        send_directed("one",       1'b0, 8'd127, 25'h0800000, 3'b000, {3'b000, 32'h3F80_0000});
        send_directed("carry",     1'b0, 8'd127, 25'h1000000, 3'b000, {3'b000, 32'h4000_0000});
        send_directed("tie_odd",   1'b0, 8'd127, 25'h0800001, 3'b100, {3'b001, 32'h3F80_0002});
        send_directed("lz23",      1'b0, 8'd127, 25'h0000001, 3'b000, {3'b000, 32'h3400_0000});
        send_directed("overflow",  1'b0, 8'd254, 25'h1FFFFFF, 3'b000, {3'b101, 32'h7F80_0000});
        send_directed("neg_zero",  1'b1, 8'd0,   25'h0000000, 3'b000, {3'b000, 32'h8000_0000});
        send_directed("underflow", 1'b0, 8'd1,   25'h0000003, 3'b100, {3'b011, 32'h0000_0004});
        send_directed("den_to_nrm", 1'b0, 8'd1,  25'h07FFFFF, 3'b110, {3'b001, 32'h0080_0000});
        send_directed("exp0_den",  1'b0, 8'd0,   25'h0400000, 3'b000, {3'b000, 32'h0040_0000});

        // Back-to-back with the sink stalled for three cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_exp    = 8'd127;
        in_mant   = 25'h0800000;
        in_grs    = 3'b000;
        @(negedge clk);
        check("b2b_ready_a", 35'(in_ready), 35'd1);
        @(posedge clk); #1;
        in_mant = 25'h1000000;
        @(negedge clk);
        check("b2b_ready_b", 35'(in_ready), 35'd1);
        @(posedge clk); #1;
        in_mant = 25'h0800001;
        in_grs  = 3'b100;
        @(negedge clk);
        check("b2b_stall_ready", 35'(in_ready), 35'd0);
        check("b2b_out_a", {out_flags, out_result}, {3'b000, 32'h3F80_0000});
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_resume_ready", 35'(in_ready), 35'd1);
        check("b2b_out_a_held", {out_flags, out_result}, {3'b000, 32'h3F80_0000});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_b", {out_flags, out_result}, {3'b000, 32'h4000_0000});
        @(negedge clk);
        check("b2b_out_c", {out_flags, out_result}, {3'b001, 32'h3F80_0002});
        repeat (3) @(negedge clk);

        // Reset with two operands in flight: neither may emerge.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_operand();
        @(posedge clk); #1;
        rand_operand();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rstmid_out_valid", 35'(out_valid), 35'd0);
        check("rstmid_out_data", {out_flags, out_result}, 35'd0);
        check("rstmid_in_ready", 35'(in_ready), 35'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_no_emit", 35'(out_valid), 35'd0);
        end

        // Randomized traffic; operands are held until accepted.
        @(posedge clk); #1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_operand();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("drain_empty", 35'(sb.size()), 35'd0);
        check("drain_out_valid", 35'(out_valid), 35'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have parameter EXP_W, default 8, biased exponent width; only 8 supported.
REQ-002 SHALL have parameter MAN_W, default 24, significand width including hidden bit; only 24 supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream holds a valid operand.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand this cycle.
REQ-007 SHALL have port in_sign  input  1  result sign.
REQ-008 SHALL have port in_exp  input  8  biased exponent of the unnormalized sum.
REQ-009 SHALL have port in_mant  input  25  unnormalized significand; bit 24 is the adder carry-out, bit 23 the hidden-bit position.
REQ-010 SHALL have port in_grs  input  3  guard, round, sticky, MSB first, from the alignment right shift.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_result  output  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}.
REQ-014 SHALL have port out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds and packs; an accepted operand appears on out_valid exactly 2 cycles later with no stall.
REQ-016 SHALL transfer on in_valid&in_ready and on out_valid&out_ready only.
REQ-017 SHALL drive in_ready = !S1_valid | (!S2_valid | out_ready), the full-throughput rule; no combinational path from in_valid to in_ready.
REQ-018 SHALL hold out_result and out_flags stable while out_valid=1 and out_ready=0.
REQ-019 S1 carry case, in_mant[24]=1: mant>>1, exp+1, new G=mant[0], R=old G, S=old R|old S.
REQ-020 S1 left case, in_mant[24]=0: lz = leading zeros of in_mant[23:0], 0..24; shift k = min(lz, in_exp-1), or 0 when in_exp=0.
REQ-021 S1 left shift fill order: old G enters first, then old R, then zeros; after the shift, G=R (k=1) or 0 (k>=2), R=0, S unchanged.
REQ-022 S1 exponent: in_exp-k; 0 when the post-shift bit 23 is 0, the denormal case.
REQ-023 S1 SHALL use a 10-bit internal exponent so that carry to 255 and subtraction cannot wrap.
REQ-024 S2 SHALL round to nearest even: increment when G&(R|S|lsb).
REQ-025 S2: if the increment carries out of bit 23, frac=0 and exp+1; a denormal rounding into bit 23 sets exp=1.
REQ-026 Exp>=255 after rounding SHALL give {sign,8'hFF,23'h0} and flag overflow=1, inexact=1.
REQ-027 in_mant=0 with grs=0 SHALL give signed zero, flags 0.
REQ-028 inexact SHALL equal G|R|S before rounding; underflow SHALL equal inexact & (final exp==0).

Reset
REQ-029 rst_n=0 at a clock edge SHALL clear S1_valid, S2_valid, out_result and out_flags to 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 Reset mid-operation SHALL discard in-flight operands without emitting them.

Structure
REQ-031 SHALL take IEEE single field widths, bias 127 and the flag bit positions from the shared package fpu_pkg.
REQ-032 SHALL place the leading-zero count in one sub-module, fp_lzc24: 24-bit input, 5-bit count, all-zero input gives 24.

Verification
REQ-033 mant=25'h0800000, exp=127, grs=000 -> 0x3F800000, flags 000, exactly 2 cycles after acceptance.
REQ-034 mant=25'h1000000, exp=127, grs=000 -> 0x40000000, flags 000.
REQ-035 mant=25'h0800001, exp=127, grs=100 -> tie, odd lsb rounds up -> 0x3F800002, inexact=1.
REQ-036 mant=25'h0000001, exp=127, grs=000 -> lz=23, result 0x34000000.
REQ-037 mant=25'h1FFFFFF, exp=254 -> 0x7F800000, overflow=1, inexact=1.
REQ-038 Back-to-back inputs with out_ready low for 3 cycles -> in_ready drops after 2 accepts, outputs held, no loss or duplication, order preserved.
